// File: rtl/kernel_action_stub_pkg.sv
// Shared types and helpers for the kernel action stub:
// FSM state encodings, AXI response codes, address decode.
package kernel_action_stub_pkg;

   typedef enum logic [1:0] {
      A_IDLE,
      A_BUSY,
      A_DONE
   } act_state_t;

   typedef enum logic [1:0] {
      R_IDLE,
      R_ADDR,
      R_RESP
   } rd_state_t;

   typedef enum logic [1:0] {
      W_IDLE,
      W_ACC,
      W_RESP
   } wr_state_t;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   function automatic int addr_lsb(input int data_width);
      return $clog2(data_width / 8);
   endfunction

endpackage

// File: rtl/axil_regfile_slave.sv
// AXI-lite slave: RW register file plus one read-only word
// placed directly after the RW registers.
module axil_regfile_slave
   import kernel_action_stub_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int NUM_REGS   = 8
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [DATA_WIDTH-1:0]     ro_word,
   input  logic [ADDR_WIDTH-1:0]     s_axi_araddr,
   input  logic                      s_axi_arvalid,
   output logic                      s_axi_arready,
   output logic [DATA_WIDTH-1:0]     s_axi_rdata,
   output logic [1:0]                s_axi_rresp,
   output logic                      s_axi_rvalid,
   input  logic                      s_axi_rready,
   input  logic [ADDR_WIDTH-1:0]     s_axi_awaddr,
   input  logic                      s_axi_awvalid,
   output logic                      s_axi_awready,
   input  logic [DATA_WIDTH-1:0]     s_axi_wdata,
   input  logic [DATA_WIDTH/8-1:0]   s_axi_wstrb,
   input  logic                      s_axi_wvalid,
   output logic                      s_axi_wready,
   output logic [1:0]                s_axi_bresp,
   output logic                      s_axi_bvalid,
   input  logic                      s_axi_bready
);

   localparam int LSB = addr_lsb(DATA_WIDTH);
   localparam int IW  = ADDR_WIDTH - LSB;
   localparam int NB  = DATA_WIDTH / 8;
   localparam logic [IW-1:0] RO_IDX = IW'(NUM_REGS);

   rd_state_t rd_state, rd_next;
   wr_state_t wr_state, wr_next;

   logic [DATA_WIDTH-1:0] regs [NUM_REGS];
   logic [DATA_WIDTH-1:0] rd_word;
   logic [1:0]            rd_resp;
   logic [DATA_WIDTH-1:0] rdata_q;
   logic [1:0]            rresp_q;
   logic [1:0]            bresp_q;
   logic [IW-1:0]         rd_idx;
   logic [IW-1:0]         wr_idx;
   logic                  wr_ok;
   logic                  unused_ok;

   assign rd_idx    = s_axi_araddr[ADDR_WIDTH-1:LSB];
   assign wr_idx    = s_axi_awaddr[ADDR_WIDTH-1:LSB];
   assign wr_ok     = wr_idx < RO_IDX;
   assign unused_ok = ^{s_axi_araddr[LSB-1:0],
                        s_axi_awaddr[LSB-1:0]};

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_state <= R_IDLE;
         wr_state <= W_IDLE;
      end else begin
         rd_state <= rd_next;
         wr_state <= wr_next;
      end
   end

   always_comb begin
      rd_next = rd_state;
      unique case (rd_state)
         R_IDLE:  if (s_axi_arvalid) rd_next = R_ADDR;
         R_ADDR:  rd_next = R_RESP;
         R_RESP:  if (s_axi_rready) rd_next = R_IDLE;
         default: rd_next = R_IDLE;
      endcase
   end

   always_comb begin
      wr_next = wr_state;
      unique case (wr_state)
         W_IDLE: begin
            if (s_axi_awvalid && s_axi_wvalid)
               wr_next = W_ACC;
         end
         W_ACC:   wr_next = W_RESP;
         W_RESP:  if (s_axi_bready) wr_next = W_IDLE;
         default: wr_next = W_IDLE;
      endcase
   end

   always_comb begin
      rd_word = '0;
      rd_resp = RESP_SLVERR;
      if (rd_idx == RO_IDX) begin
         rd_word = ro_word;
         rd_resp = RESP_OKAY;
      end
      for (int i = 0; i < NUM_REGS; i++) begin
         if (rd_idx == IW'(i)) begin
            rd_word = regs[i];
            rd_resp = RESP_OKAY;
         end
      end
   end

   // Latched before any same-cycle commit lands: reads see old data
   always_ff @(posedge clk) begin
      if (reset) begin
         rdata_q <= '0;
         rresp_q <= RESP_OKAY;
      end else if (rd_state == R_ADDR) begin
         rdata_q <= rd_word;
         rresp_q <= rd_resp;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         bresp_q <= RESP_OKAY;
      end else if (wr_state == W_ACC) begin
         bresp_q <= wr_ok ? RESP_OKAY : RESP_SLVERR;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NUM_REGS; i++)
            regs[i] <= '0;
      end else if (wr_state == W_ACC) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            if (wr_idx == IW'(i)) begin
               for (int b = 0; b < NB; b++) begin
                  if (s_axi_wstrb[b])
                     regs[i][8*b +: 8] <= s_axi_wdata[8*b +: 8];
               end
            end
         end
      end
   end

   assign s_axi_arready = (rd_state == R_ADDR);
   assign s_axi_rvalid  = (rd_state == R_RESP);
   assign s_axi_rdata   = rdata_q;
   assign s_axi_rresp   = rresp_q;
   assign s_axi_awready = (wr_state == W_ACC);
   assign s_axi_wready  = (wr_state == W_ACC);
   assign s_axi_bvalid  = (wr_state == W_RESP);
   assign s_axi_bresp   = bresp_q;

endmodule

// File: rtl/kernel_action_stub_regs.sv
// Kernel action stub: AXI-lite register file plus a go/done
// engine with fixed latency and a completion counter.
module kernel_action_stub_regs
   import kernel_action_stub_pkg::*;
#(
   parameter int ADDR_WIDTH   = 32,
   parameter int DATA_WIDTH   = 32,
   parameter int NUM_REGS     = 8,
   parameter int DONE_LATENCY = 0
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      action_go_valid,
   output logic                      action_go_holdoff,
   output logic                      action_done_valid,
   input  logic                      action_done_stop,
   input  logic [ADDR_WIDTH-1:0]     s_axi_araddr,
   input  logic                      s_axi_arvalid,
   output logic                      s_axi_arready,
   output logic [DATA_WIDTH-1:0]     s_axi_rdata,
   output logic [1:0]                s_axi_rresp,
   output logic                      s_axi_rvalid,
   input  logic                      s_axi_rready,
   input  logic [ADDR_WIDTH-1:0]     s_axi_awaddr,
   input  logic                      s_axi_awvalid,
   output logic                      s_axi_awready,
   input  logic [DATA_WIDTH-1:0]     s_axi_wdata,
   input  logic [DATA_WIDTH/8-1:0]   s_axi_wstrb,
   input  logic                      s_axi_wvalid,
   output logic                      s_axi_wready,
   output logic [1:0]                s_axi_bresp,
   output logic                      s_axi_bvalid,
   input  logic                      s_axi_bready
);

   localparam int CW =
      (DONE_LATENCY > 1) ? $clog2(DONE_LATENCY) : 1;

   act_state_t            act_state, act_next;
   logic [CW-1:0]         cnt, cnt_n;
   logic                  done_inc;
   logic [DATA_WIDTH-1:0] done_count;

   always_ff @(posedge clk) begin
      if (reset) begin
         act_state  <= A_IDLE;
         cnt        <= '0;
         done_count <= '0;
      end else begin
         act_state <= act_next;
         cnt       <= cnt_n;
         if (done_inc)
            done_count <= done_count + DATA_WIDTH'(1);
      end
   end

   // Zero latency skips BUSY so done follows go by one cycle
   always_comb begin
      act_next = act_state;
      cnt_n    = cnt;
      done_inc = 1'b0;
      unique case (act_state)
         A_IDLE: begin
            if (action_go_valid) begin
               if (DONE_LATENCY == 0) begin
                  act_next = A_DONE;
               end else begin
                  act_next = A_BUSY;
                  cnt_n    = CW'(DONE_LATENCY - 1);
               end
            end
         end
         A_BUSY: begin
            if (cnt == '0)
               act_next = A_DONE;
            else
               cnt_n = cnt - CW'(1);
         end
         A_DONE: begin
            if (!action_done_stop) begin
               act_next = A_IDLE;
               done_inc = 1'b1;
            end
         end
         default: act_next = A_IDLE;
      endcase
   end

   assign action_go_holdoff = (act_state != A_IDLE);
   assign action_done_valid = (act_state == A_DONE);

   axil_regfile_slave #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH),
      .NUM_REGS   (NUM_REGS)
   ) u_regs (
      .clk           (clk),
      .reset         (reset),
      .ro_word       (done_count),
      .s_axi_araddr  (s_axi_araddr),
      .s_axi_arvalid (s_axi_arvalid),
      .s_axi_arready (s_axi_arready),
      .s_axi_rdata   (s_axi_rdata),
      .s_axi_rresp   (s_axi_rresp),
      .s_axi_rvalid  (s_axi_rvalid),
      .s_axi_rready  (s_axi_rready),
      .s_axi_awaddr  (s_axi_awaddr),
      .s_axi_awvalid (s_axi_awvalid),
      .s_axi_awready (s_axi_awready),
      .s_axi_wdata   (s_axi_wdata),
      .s_axi_wstrb   (s_axi_wstrb),
      .s_axi_wvalid  (s_axi_wvalid),
      .s_axi_wready  (s_axi_wready),
      .s_axi_bresp   (s_axi_bresp),
      .s_axi_bvalid  (s_axi_bvalid),
      .s_axi_bready  (s_axi_bready)
   );

endmodule

// File: tb/tb_kernel_action_stub_regs.sv
// Bench for kernel_action_stub_regs: transaction-level model
// checked every cycle, plus directed literal checks.
module tb_kernel_action_stub_regs;

   localparam int NR = 8;
   localparam int LAT = 5;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        action_go_valid = 1'b0;
   logic        action_go_holdoff;
   logic        action_done_valid;
   logic        action_done_stop = 1'b0;
   logic [31:0] s_axi_araddr = '0;
   logic        s_axi_arvalid = 1'b0;
   logic        s_axi_arready;
   logic [31:0] s_axi_rdata;
   logic [1:0]  s_axi_rresp;
   logic        s_axi_rvalid;
   logic        s_axi_rready = 1'b0;
   logic [31:0] s_axi_awaddr = '0;
   logic        s_axi_awvalid = 1'b0;
   logic        s_axi_awready;
   logic [31:0] s_axi_wdata = '0;
   logic [3:0]  s_axi_wstrb = '0;
   logic        s_axi_wvalid = 1'b0;
   logic        s_axi_wready;
   logic [1:0]  s_axi_bresp;
   logic        s_axi_bvalid;
   logic        s_axi_bready = 1'b0;

   int vectors = 0;
   int miscompares = 0;

   kernel_action_stub_regs #(
      .ADDR_WIDTH   (32),
      .DATA_WIDTH   (32),
      .NUM_REGS     (NR),
      .DONE_LATENCY (LAT)
   ) dut (
      .clk               (clk),
      .reset             (reset),
      .action_go_valid   (action_go_valid),
      .action_go_holdoff (action_go_holdoff),
      .action_done_valid (action_done_valid),
      .action_done_stop  (action_done_stop),
      .s_axi_araddr      (s_axi_araddr),
      .s_axi_arvalid     (s_axi_arvalid),
      .s_axi_arready     (s_axi_arready),
      .s_axi_rdata       (s_axi_rdata),
      .s_axi_rresp       (s_axi_rresp),
      .s_axi_rvalid      (s_axi_rvalid),
      .s_axi_rready      (s_axi_rready),
      .s_axi_awaddr      (s_axi_awaddr),
      .s_axi_awvalid     (s_axi_awvalid),
      .s_axi_awready     (s_axi_awready),
      .s_axi_wdata       (s_axi_wdata),
      .s_axi_wstrb       (s_axi_wstrb),
      .s_axi_wvalid      (s_axi_wvalid),
      .s_axi_wready      (s_axi_wready),
      .s_axi_bresp       (s_axi_bresp),
      .s_axi_bvalid      (s_axi_bvalid),
      .s_axi_bready      (s_axi_bready)
   );

   always #5 clk = ~clk;

   // Reference model: register array, counter, and channel timelines
   logic [31:0] m_regs [NR];
   logic [31:0] m_cnt;
   int          cyc = 0;
   int          go_t = 0;
   bit          busy = 0;
   logic        e_arready = 0, e_rvalid = 0;
   logic        e_awready = 0, e_bvalid = 0;
   logic        e_holdoff = 0, e_done = 0;
   logic [31:0] e_rdata = '0;
   logic [1:0]  e_rresp = '0, e_bresp = '0;

   function automatic logic [33:0] mlook(input logic [31:0] a);
      logic [29:0] idx;
      idx = a[31:2];
      if (idx < 30'(NR)) return {2'b00, m_regs[int'(idx)]};
      if (idx == 30'(NR)) return {2'b00, m_cnt};
      return {2'b10, 32'h0};
   endfunction

   always @(posedge clk) begin
      logic [33:0] lk;
      logic [29:0] widx;
      cyc++;
      if (reset) begin
         for (int i = 0; i < NR; i++) m_regs[i] = '0;
         m_cnt = '0;
         busy = 0;
         {e_arready, e_rvalid, e_awready, e_bvalid} = '0;
         {e_holdoff, e_done} = '0;
         e_rdata = '0; e_rresp = '0; e_bresp = '0;
      end else begin
         if (e_arready) begin
            lk = mlook(s_axi_araddr);
            {e_rresp, e_rdata} = lk;
            e_arready = 0;
            e_rvalid = 1;
         end else if (e_rvalid) begin
            if (s_axi_rready) e_rvalid = 0;
         end else if (s_axi_arvalid) begin
            e_arready = 1;
         end
         if (e_awready) begin
            widx = s_axi_awaddr[31:2];
            if (widx < 30'(NR)) begin
               for (int b = 0; b < 4; b++)
                  if (s_axi_wstrb[b])
                     m_regs[int'(widx)][8*b +: 8] =
                        s_axi_wdata[8*b +: 8];
               e_bresp = 2'b00;
            end else begin
               e_bresp = 2'b10;
            end
            e_awready = 0;
            e_bvalid = 1;
         end else if (e_bvalid) begin
            if (s_axi_bready) e_bvalid = 0;
         end else if (s_axi_awvalid && s_axi_wvalid) begin
            e_awready = 1;
         end
         if (e_done && !action_done_stop) begin
            busy = 0;
            m_cnt = m_cnt + 32'd1;
         end else if (!busy && action_go_valid) begin
            busy = 1;
            go_t = cyc - 1;
         end
         e_holdoff = busy;
         e_done = busy && (cyc >= go_t + LAT + 1);
      end
   end

   always @(negedge clk) begin
      if (cyc >= 1) begin
         vectors++;
         if (s_axi_arready !== e_arready ||
             s_axi_rvalid  !== e_rvalid  ||
             s_axi_awready !== e_awready ||
             s_axi_wready  !== e_awready ||
             s_axi_bvalid  !== e_bvalid  ||
             action_go_holdoff !== e_holdoff ||
             action_done_valid !== e_done ||
             (e_rvalid && (s_axi_rdata !== e_rdata ||
                           s_axi_rresp !== e_rresp)) ||
             (e_bvalid && s_axi_bresp !== e_bresp)) begin
            miscompares++;
            $display("FAIL model cyc %0d: got ar%b r%b d%h rr%h aw%b w%b b%b br%h h%b dn%b exp ar%b r%b d%h rr%h aw%b b%b br%h h%b dn%b",
               cyc, s_axi_arready, s_axi_rvalid, s_axi_rdata,
               s_axi_rresp, s_axi_awready, s_axi_wready,
               s_axi_bvalid, s_axi_bresp, action_go_holdoff,
               action_done_valid, e_arready, e_rvalid, e_rdata,
               e_rresp, e_awready, e_bvalid, e_bresp, e_holdoff,
               e_done);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name,
                        input logic [63:0] got,
                        input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h expected 0x%0h",
                  name, got, exp);
      end
   endtask

   task automatic check_all_zero(input string name);
      check(name, {s_axi_arready, s_axi_rvalid, s_axi_rdata,
                   s_axi_rresp, s_axi_awready, s_axi_wready,
                   s_axi_bvalid, s_axi_bresp, action_go_holdoff,
                   action_done_valid}, 64'h0);
   endtask

   task automatic axi_read(input logic [31:0] addr,
                           input int hold,
                           output logic [31:0] data,
                           output logic [1:0] resp,
                           output int lat_ar,
                           output int lat_r);
      s_axi_araddr = addr;
      s_axi_arvalid = 1;
      s_axi_rready = 0;
      lat_ar = 0;
      while (!s_axi_arready && lat_ar < 16) begin
         step();
         lat_ar++;
      end
      if (!s_axi_arready) check("arready timeout", 0, 1);
      step();
      s_axi_arvalid = 0;
      lat_r = lat_ar + 1;
      while (!s_axi_rvalid && lat_r < 32) begin
         step();
         lat_r++;
      end
      if (!s_axi_rvalid) check("rvalid timeout", 0, 1);
      data = s_axi_rdata;
      resp = s_axi_rresp;
      repeat (hold) begin
         step();
         check("rvalid held", s_axi_rvalid, 1);
         check("no arready while held", s_axi_arready, 0);
      end
      s_axi_rready = 1;
      step();
      s_axi_rready = 0;
   endtask

   task automatic axi_write(input logic [31:0] addr,
                            input logic [31:0] data,
                            input logic [3:0] strb,
                            input int hold,
                            output logic [1:0] resp,
                            output int lat_aw);
      s_axi_awaddr = addr;
      s_axi_wdata = data;
      s_axi_wstrb = strb;
      s_axi_awvalid = 1;
      s_axi_wvalid = 1;
      lat_aw = 0;
      while (!s_axi_awready && lat_aw < 16) begin
         step();
         lat_aw++;
      end
      if (!s_axi_awready) check("awready timeout", 0, 1);
      step();
      s_axi_awvalid = 0;
      s_axi_wvalid = 0;
      for (int n = 0; n < 16 && !s_axi_bvalid; n++) step();
      if (!s_axi_bvalid) check("bvalid timeout", 0, 1);
      resp = s_axi_bresp;
      repeat (hold) begin
         step();
         check("bvalid held", s_axi_bvalid, 1);
         check("no awready while held", s_axi_awready, 0);
      end
      s_axi_bready = 1;
      step();
      s_axi_bready = 0;
   endtask

   function automatic logic [31:0] rand_addr();
      logic [31:0] a;
      a = {$urandom_range(0, NR + 2), 2'b00};
      a[1:0] = 2'($urandom);
      if ($urandom_range(0, 9) == 0) a[31] = 1'b1;
      return a;
   endfunction

   initial begin
      logic [31:0] d;
      logic [1:0]  r;
      int la, lr, n;
      bit ar_hs, aw_hs;

      repeat (3) step();
      reset = 0;
      repeat (10) step();
      check_all_zero("idle after reset");

      axi_write(32'd2 << 2, 32'hDEADBEEF, 4'b0101, 0, r, la);
      check("wr idx2 bresp", r, 2'b00);
      check("wr awready latency", la, 1);
      axi_read(32'd2 << 2, 0, d, r, la, lr);
      check("rd idx2 data", d, 32'h00AD00EF);
      check("rd idx2 rresp", r, 2'b00);
      check("rd arready latency", la, 1);
      check("rd rvalid latency", lr, 2);

      axi_read((NR + 1) << 2, 0, d, r, la, lr);
      check("rd unmapped data", d, 0);
      check("rd unmapped rresp", r, 2'b10);
      axi_write(NR << 2, 32'hFFFFFFFF, 4'hF, 0, r, la);
      check("wr done_count bresp", r, 2'b10);
      axi_read(NR << 2, 0, d, r, la, lr);
      check("done_count unchanged", d, 0);

      action_go_valid = 1;
      step();
      action_go_valid = 0;
      check("holdoff after go", action_go_holdoff, 1);
      n = 1;
      while (!action_done_valid && n < 20) begin
         step();
         n++;
      end
      check("go to done latency", n, LAT + 1);
      action_done_stop = 1;
      repeat (3) begin
         check("done held by stop", action_done_valid, 1);
         step();
      end
      action_done_stop = 0;
      check("done still high", action_done_valid, 1);
      step();
      check("done released", action_done_valid, 0);
      check("holdoff released", action_go_holdoff, 0);
      axi_read(NR << 2, 0, d, r, la, lr);
      check("done_count after one", d, 1);

      axi_write(32'd5 << 2, 32'h12345678, 4'hF, 4, r, la);
      check("wr idx5 bresp", r, 2'b00);
      axi_read(32'd5 << 2 | 32'd3, 4, d, r, la, lr);
      check("rd idx5 low bits ignored", d, 32'h12345678);

      for (int k = 0; k < 3000; k++) begin
         ar_hs = s_axi_arvalid && s_axi_arready;
         aw_hs = s_axi_awvalid && s_axi_awready;
         step();
         reset = 0;
         if (ar_hs) s_axi_arvalid = 0;
         if (aw_hs) begin
            s_axi_awvalid = 0;
            s_axi_wvalid = 0;
         end
         if (!s_axi_arvalid && $urandom_range(0, 2) == 0) begin
            s_axi_araddr = rand_addr();
            s_axi_arvalid = 1;
         end
         if (!s_axi_awvalid && $urandom_range(0, 2) == 0) begin
            s_axi_awaddr = rand_addr();
            s_axi_wdata = $urandom;
            s_axi_wstrb = 4'($urandom);
            s_axi_awvalid = 1;
            s_axi_wvalid = 1;
         end
         s_axi_rready = 1'($urandom_range(0, 1));
         s_axi_bready = 1'($urandom_range(0, 1));
         action_go_valid = ($urandom_range(0, 3) == 0);
         action_done_stop = ($urandom_range(0, 2) == 0);
         if ($urandom_range(0, 399) == 0) begin
            reset = 1;
            s_axi_arvalid = 0;
            s_axi_awvalid = 0;
            s_axi_wvalid = 0;
         end
      end

      reset = 0;
      s_axi_arvalid = 0;
      s_axi_awvalid = 0;
      s_axi_wvalid = 0;
      action_go_valid = 0;
      action_done_stop = 0;
      s_axi_rready = 1;
      s_axi_bready = 1;
      repeat (20) step();
      s_axi_rready = 0;
      s_axi_bready = 0;
      step();

      action_go_valid = 1;
      step();
      action_go_valid = 0;
      s_axi_araddr = 32'd2 << 2;
      s_axi_arvalid = 1;
      step();
      step();
      s_axi_arvalid = 0;
      check("rvalid before reset", s_axi_rvalid, 1);
      check("busy before reset", action_go_holdoff, 1);
      reset = 1;
      step();
      reset = 0;
      check_all_zero("outputs after mid reset");
      step();
      action_go_valid = 1;
      step();
      action_go_valid = 0;
      n = 1;
      while (!action_done_valid && n < 20) begin
         step();
         n++;
      end
      check("post reset go latency", n, LAT + 1);
      step();
      axi_read(NR << 2, 0, d, r, la, lr);
      check("done_count after reset", d, 1);
      axi_read(32'd2 << 2, 0, d, r, la, lr);
      check("regs cleared by reset", d, 0);

      repeat (2) step();
      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

endmodule
